alu_issue_sched: RTL and testbench
==================================

# alu_issue_sched

Parametrised oldest-first issue scheduler for the integer ALU cluster. Tracks a per-commit-slot state machine across NCOMMIT slots and each cycle selects up to NALU ready entries, scanning from the commit head, for the ALU issue ports. It is the generalised successor to the fixed-configuration ALU scheduler:
- arbitrary ALU count;
- per-port back-pressure;
- replay of issued ops;
- ranged kill on mispredict.

## Interface
- NCOMMIT, 32: commit slots; power of two, 8..64.
- LNCOMMIT, $clog2(NCOMMIT): slot index width.
- NALU, 2: issue ports, 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- head  in  LNCOMMIT  oldest live commit slot (commit pointer).
- alloc_mask  in  NCOMMIT  slots newly allocated by rename this cycle.
- alloc_rdy  in  NCOMMIT  operands already available at allocation (qualified by alloc_mask).
- wake_mask  in  NCOMMIT  operand wakeups from the bypass/writeback network.
- replay_mask  in  NCOMMIT  issued ops to be cancelled and re-waited (e.g. load miss shadow).
- done_mask  in  NCOMMIT  slots retired or written back; entry freed.
- kill_valid  in  1  mispredict kill request.
- kill_from  in  LNCOMMIT  first killed slot; kill covers kill_from up to, but not including, head (wrapping).
- issue_ready  in  NALU  ALU port p can accept an op this cycle.
- issue_valid  out  NALU  port p carries an op.
- issue_slot  out  NALU*LNCOMMIT  slot for port p, packed as bits [p*LNCOMMIT +: LNCOMMIT].
- pending_count  out  LNCOMMIT+1  registered count of entries in WAIT or READY.

## Operation
- Per-slot 2-bit state: EMPTY, WAIT, READY, ISSUED. All slots reset to EMPTY; pending_count resets to 0; issue_valid is 0 during reset.
- Selection (combinational from registered state):
  - Rotate the READY vector by head so bit 0 is oldest.
  - Find the first NALU set bits in age order.
  - The k-th oldest READY entry goes to the k-th port with issue_ready=1; ports with issue_ready=0 are skipped and receive nothing.
  - Unused ports drive issue_valid=0 and issue_slot=0.
  - issue_slot = (rotated index + head) mod NCOMMIT.
- A handshake fires when issue_valid and issue_ready are both 1 (issue_valid already implies issue_ready). The entry moves READY→ISSUED at that edge.
- Next-state per slot, highest priority first:
  1. kill: slot in the kill range and not EMPTY → EMPTY.
  2. alloc_mask: → READY if alloc_rdy, else WAIT. Applied after kill, so a same-cycle allocation survives a kill covering its slot. Allocation of a non-EMPTY, non-killed slot is a protocol error; the slot is overwritten.
  3. done_mask: any state → EMPTY.
  4. replay_mask: ISSUED → WAIT. Ignored in other states.
  5. issue handshake: READY → ISSUED.
  6. wake_mask: WAIT → READY. Ignored in other states.
- Kill range: slots s with (s − kill_from) mod NCOMMIT < (head − kill_from) mod NCOMMIT. If kill_from == head, the range is empty; nothing is killed.
- pending_count is the next-state population of WAIT|READY, registered.

## Timing
- Alloc with alloc_rdy=1 at edge N: eligible for issue in cycle N+1, giving a one-cycle alloc-to-issue minimum.
- Wake at edge N: eligible in cycle N+1. There is no same-cycle wake-to-issue bypass.
- Replay at edge N: the entry is WAIT in N+1 and needs a fresh wake before it can be selected again.
- Issue outputs change only with state, head, or issue_ready; there is no output register.
- head may advance in any cycle; age order follows the current head.
- Simultaneous wake and replay on one slot: replay wins and the slot ends in WAIT; the wake is lost.
- Simultaneous done and issue on one slot: the slot goes to EMPTY.
- Reset asserted mid-operation: all slots go to EMPTY immediately (asynchronous). Outputs are 0 until the first edge after deassertion.

## Structure
- Package alu_sched_pkg holds:
  - typedef enum logic [1:0] slot_state_t {EMPTY, WAIT, READY, ISSUED};
  - localparam MAX_NALU = 4.
- Sub-module sched_rot: a parametrised NCOMMIT barrel rotator. Instantiated twice: rotate READY by head, and rotate kill-range masks.
- Priority pick is a generate loop of NALU cascaded find-first-set stages over the rotated vector, each stage masking out earlier picks.

## Test plan
- NCOMMIT=32, NALU=3, head=30. Alloc slots 30, 31, 0, 1 with alloc_rdy=1, all issue_ready=1.
  - Next cycle: issue_slot = 30, 31, 0.
  - Following cycle: port0 = 1; pending_count goes 4 → 1 → 0.
- Same setup, issue_ready=3'b101: port0 = 30, port1 idle, port2 = 31.
- Slot 5 in WAIT, head=0:
  - wake slot 5 at edge N → issue_valid[0]=1, issue_slot[0]=5 in cycle N+1;
  - replay slot 5 at N+2 → no issue in N+3 until re-woken.
- head=4, slots 4..12 WAIT, kill_from=9 with alloc_mask bit 10 set in the same cycle:
  - slots 9, 11, 12 → EMPTY; slot 10 → WAIT; slots 4..8 unchanged; pending_count = 6.
- kill_from == head = 7 with slots 7..9 READY: nothing is killed and all three issue.
- Assert reset while 3 entries are ISSUED and 2 are READY:
  - all issue_valid = 0 and pending_count = 0 immediately;
  - after deassertion no issue occurs until new allocations.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU issue scheduler: per-slot state encoding and
// the supported issue-port ceiling.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        WAIT   = 2'd1,
        READY  = 2'd2,
        ISSUED = 2'd3
    } slot_state_t;

    localparam int MAX_NALU = 4;

endpackage

// File: rtl/sched_rot.sv
// Barrel rotator over an N-bit slot vector. Output bit i takes input bit
// (i + amt) mod N, so rotating by the commit head puts the oldest slot at
// bit 0, and rotating by -base moves an age-ordered mask back to slot order.
module sched_rot #(
    parameter int N  = 32,
    parameter int LN = $clog2(N)
) (
    input  logic [N-1:0]  din,
    input  logic [LN-1:0] amt,
    output logic [N-1:0]  dout
);

    logic [LN-1:0] src;

    // N is a power of two, so the LN-bit sum wraps modulo N for free.
    always_comb begin
        dout = '0;
        src  = '0;
        for (int i = 0; i < N; i++) begin
            src     = LN'(i) + amt;
            dout[i] = din[src];
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Oldest-first issue scheduler for the integer ALU cluster. Holds a 2-bit
// state per commit slot and each cycle hands up to NALU READY entries, in
// age order from the commit head, to the ALU ports that can accept them.
module alu_issue_sched
    import alu_sched_pkg::*;
#(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = $clog2(NCOMMIT),
    parameter int NALU     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LNCOMMIT-1:0]      head,
    input  logic [NCOMMIT-1:0]       alloc_mask,
    input  logic [NCOMMIT-1:0]       alloc_rdy,
    input  logic [NCOMMIT-1:0]       wake_mask,
    input  logic [NCOMMIT-1:0]       replay_mask,
    input  logic [NCOMMIT-1:0]       done_mask,
    input  logic                     kill_valid,
    input  logic [LNCOMMIT-1:0]      kill_from,
    input  logic [NALU-1:0]          issue_ready,
    output logic [NALU-1:0]          issue_valid,
    output logic [NALU*LNCOMMIT-1:0] issue_slot,
    output logic [LNCOMMIT:0]        pending_count
);

    slot_state_t          st_p1  [NCOMMIT];
    slot_state_t          st_nxt [NCOMMIT];
    logic [LNCOMMIT:0]    pend_nxt;

    logic [NCOMMIT-1:0]   ready_vec;
    logic [NCOMMIT-1:0]   ready_rot;
    logic [NCOMMIT-1:0]   kill_therm;
    logic [NCOMMIT-1:0]   kill_mask;
    logic [LNCOMMIT-1:0]  kill_len;
    logic [LNCOMMIT-1:0]  kill_amt;
    logic [NCOMMIT-1:0]   fire_mask;
    logic [NALU-1:0][NCOMMIT-1:0] remain;

    // Lowest set bit of v: {found, index}.
    function automatic logic [LNCOMMIT:0] ffs(input logic [NCOMMIT-1:0] v);
        logic [LNCOMMIT:0] r;
        r = '0;
        for (int i = NCOMMIT - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, LNCOMMIT'(i)};
        end
        return r;
    endfunction

    // READY vector in slot order, the input to age-ordered selection.
    always_comb begin
        ready_vec = '0;
        for (int s = 0; s < NCOMMIT; s++) begin
            ready_vec[s] = (st_p1[s] == READY);
        end
    end

    sched_rot #(.N(NCOMMIT), .LN(LNCOMMIT)) u_rot_ready (
        .din  (ready_vec),
        .amt  (head),
        .dout (ready_rot)
    );

    // Kill range in age order starting at kill_from is a thermometer of
    // length (head - kill_from); kill_from == head yields an empty range.
    always_comb begin
        kill_len   = head - kill_from;
        kill_amt   = '0 - kill_from;
        kill_therm = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            kill_therm[i] = kill_valid && (LNCOMMIT'(i) < kill_len);
        end
    end

    sched_rot #(.N(NCOMMIT), .LN(LNCOMMIT)) u_rot_kill (
        .din  (kill_therm),
        .amt  (kill_amt),
        .dout (kill_mask)
    );

    assign remain[0] = ready_rot;

    // Cascaded find-first-set, one stage per port. A stalled port takes
    // nothing and passes the whole candidate set on to the next port.
    for (genvar p = 0; p < NALU; p++) begin : g_pick
        logic [LNCOMMIT:0] hit;
        logic              take;

        assign hit  = ffs(remain[p]);
        assign take = issue_ready[p] & hit[LNCOMMIT];
        assign issue_valid[p] = take;
        assign issue_slot[p*LNCOMMIT +: LNCOMMIT] =
            take ? (hit[LNCOMMIT-1:0] + head) : '0;

        if (p < NALU - 1) begin : g_next
            assign remain[p+1] = take
                ? (remain[p] & ~(NCOMMIT'(1) << hit[LNCOMMIT-1:0]))
                : remain[p];
        end
    end

    // Slots whose READY -> ISSUED handshake completes at this edge.
    always_comb begin
        fire_mask = '0;
        for (int p = 0; p < NALU; p++) begin
            if (issue_valid[p] && issue_ready[p]) begin
                fire_mask[issue_slot[p*LNCOMMIT +: LNCOMMIT]] = 1'b1;
            end
        end
    end

    // Per-slot next state; allocation beats a same-cycle kill so a freshly
    // renamed op survives, and replay only cancels ops already issued.
    always_comb begin
        pend_nxt = '0;
        for (int s = 0; s < NCOMMIT; s++) begin
            st_nxt[s] = st_p1[s];
            if (alloc_mask[s]) begin
                st_nxt[s] = alloc_rdy[s] ? READY : WAIT;
            end else if (kill_mask[s] && st_p1[s] != EMPTY) begin
                st_nxt[s] = EMPTY;
            end else if (done_mask[s]) begin
                st_nxt[s] = EMPTY;
            end else if (replay_mask[s] && st_p1[s] == ISSUED) begin
                st_nxt[s] = WAIT;
            end else if (fire_mask[s]) begin
                st_nxt[s] = ISSUED;
            end else if (wake_mask[s] && st_p1[s] == WAIT) begin
                st_nxt[s] = READY;
            end
            if (st_nxt[s] == WAIT || st_nxt[s] == READY) begin
                pend_nxt = pend_nxt + (LNCOMMIT + 1)'(1);
            end
        end
    end

    // Slot state and pending population registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NCOMMIT; s++) begin
                st_p1[s] <= EMPTY;
            end
            pending_count <= '0;
        end else begin
            for (int s = 0; s < NCOMMIT; s++) begin
                st_p1[s] <= st_nxt[s];
            end
            pending_count <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed scenarios plus random traffic, all
// checked by a scoreboard fed from an age-ordered reference model.
module tb_alu_issue_sched;

    localparam int N  = 32;
    localparam int LN = 5;
    localparam int NA = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [LN-1:0]   head, kill_from;
    logic [N-1:0]    alloc_mask, alloc_rdy, wake_mask, replay_mask, done_mask;
    logic            kill_valid;
    logic [NA-1:0]   issue_ready, issue_valid;
    logic [NA*LN-1:0] issue_slot;
    logic [LN:0]     pending_count;

    alu_issue_sched #(.NCOMMIT(N), .LNCOMMIT(LN), .NALU(NA)) dut (
        .clk           (clk),
        .reset         (reset),
        .head          (head),
        .alloc_mask    (alloc_mask),
        .alloc_rdy     (alloc_rdy),
        .wake_mask     (wake_mask),
        .replay_mask   (replay_mask),
        .done_mask     (done_mask),
        .kill_valid    (kill_valid),
        .kill_from     (kill_from),
        .issue_ready   (issue_ready),
        .issue_valid   (issue_valid),
        .issue_slot    (issue_slot),
        .pending_count (pending_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NA-1:0]    v;
        logic [NA*LN-1:0] s;
        int               pend;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   mst[N];     // 0 empty, 1 wait, 2 ready, 3 issued
    bit   mfire[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_port(input int p, input bit v, input int s);
        chk($sformatf("port%0d_valid", p), issue_valid[p], v);
        chk($sformatf("port%0d_slot", p), issue_slot[p*LN +: LN], s);
    endtask

    function automatic int model_pend();
        int c = 0;
        for (int s = 0; s < N; s++) if (mst[s] == 1 || mst[s] == 2) c++;
        return c;
    endfunction

    // Expected outputs: READY slots listed oldest first from head, dealt
    // in turn to the ports that are ready.
    task automatic begin_cyc();
        exp_t e;
        int   age[$];
        int   k = 0;
        #1;
        for (int a = 0; a < N; a++) begin
            int s = (int'(head) + a) % N;
            if (mst[s] == 2) age.push_back(s);
        end
        e.v = '0;
        e.s = '0;
        for (int s = 0; s < N; s++) mfire[s] = 0;
        for (int p = 0; p < NA; p++) begin
            if (issue_ready[p] && k < age.size()) begin
                e.v[p] = 1'b1;
                e.s[p*LN +: LN] = LN'(age[k]);
                mfire[age[k]] = 1;
                k++;
            end
        end
        e.pend = model_pend();
        q.push_back(e);
    endtask

    task automatic end_cyc();
        @(posedge clk);
        for (int s = 0; s < N; s++) begin
            int  kl  = (int'(head) - int'(kill_from) + N) % N;
            bit  ink = kill_valid && ((s - int'(kill_from) + N) % N < kl);
            if (alloc_mask[s])                         mst[s] = alloc_rdy[s] ? 2 : 1;
            else if (ink && mst[s] != 0)               mst[s] = 0;
            else if (done_mask[s])                     mst[s] = 0;
            else if (replay_mask[s] && mst[s] == 3)    mst[s] = 1;
            else if (mfire[s])                         mst[s] = 3;
            else if (wake_mask[s] && mst[s] == 1)      mst[s] = 2;
        end
        @(negedge clk);
        alloc_mask = '0; alloc_rdy = '0; wake_mask = '0;
        replay_mask = '0; done_mask = '0; kill_valid = 1'b0;
    endtask

    task automatic cyc();
        begin_cyc();
        end_cyc();
    endtask

    task automatic al(input int s, input bit r);
        alloc_mask[s] = 1'b1;
        alloc_rdy[s]  = r;
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_valid", issue_valid, e.v);
                chk("sb_slot", issue_slot, e.s);
                chk("sb_pend", pending_count, e.pend);
            end
        end
    end

    initial begin
        reset = 1'b0; head = '0; kill_from = '0; kill_valid = 1'b0;
        alloc_mask = '0; alloc_rdy = '0; wake_mask = '0;
        replay_mask = '0; done_mask = '0; issue_ready = '1;
        for (int s = 0; s < N; s++) mst[s] = 0;
        #2;
        chk("rst_valid", issue_valid, 0);
        chk("rst_pend", pending_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Wrapping age order across the head.
        head = 30; issue_ready = 3'b111;
        al(30, 1); al(31, 1); al(0, 1); al(1, 1);
        cyc();
        begin_cyc();
        chk_port(0, 1, 30); chk_port(1, 1, 31); chk_port(2, 1, 0);
        chk("wrap_pend4", pending_count, 4);
        end_cyc();
        begin_cyc();
        chk_port(0, 1, 1); chk_port(1, 0, 0);
        chk("wrap_pend1", pending_count, 1);
        end_cyc();
        begin_cyc();
        chk("wrap_pend0", pending_count, 0);
        end_cyc();
        done_mask = 32'h0000_0003 | 32'hC000_0000;
        cyc();

        // Stalled middle port is skipped.
        al(30, 1); al(31, 1);
        cyc();
        issue_ready = 3'b101;
        begin_cyc();
        chk_port(0, 1, 30); chk_port(1, 0, 0); chk_port(2, 1, 31);
        end_cyc();
        done_mask = 32'hC000_0000;
        cyc();

        // Wake, issue, replay, re-wake.
        head = 0; issue_ready = 3'b111;
        al(5, 0);
        cyc();
        cyc();
        wake_mask[5] = 1'b1;
        cyc();
        begin_cyc();
        chk_port(0, 1, 5);
        end_cyc();
        replay_mask[5] = 1'b1;
        cyc();
        begin_cyc();
        chk_port(0, 0, 0);
        chk("replay_pend", pending_count, 1);
        end_cyc();
        wake_mask[5] = 1'b1;
        cyc();
        begin_cyc();
        chk_port(0, 1, 5);
        end_cyc();
        done_mask[5] = 1'b1;
        cyc();

        // Ranged kill with a same-cycle allocation inside the range.
        head = 4; issue_ready = 3'b000;
        for (int s = 4; s <= 12; s++) al(s, 0);
        cyc();
        kill_valid = 1'b1; kill_from = 9; al(10, 0);
        cyc();
        begin_cyc();
        chk("kill_pend6", pending_count, 6);
        end_cyc();
        done_mask = 32'h0000_1FF0;
        cyc();

        // kill_from == head kills nothing.
        head = 7; issue_ready = 3'b000;
        al(7, 1); al(8, 1); al(9, 1);
        cyc();
        kill_valid = 1'b1; kill_from = 7;
        cyc();
        issue_ready = 3'b111;
        begin_cyc();
        chk_port(0, 1, 7); chk_port(1, 1, 8); chk_port(2, 1, 9);
        end_cyc();
        done_mask = 32'h0000_0380;
        cyc();

        // Asynchronous reset with 3 ISSUED and 2 READY entries.
        head = 0; issue_ready = 3'b000;
        for (int s = 0; s < 5; s++) al(s, 1);
        cyc();
        issue_ready = 3'b111;
        cyc();
        #1;
        chk_port(0, 1, 3); chk_port(1, 1, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", issue_valid, 0);
        chk("midrst_pend", pending_count, 0);
        for (int s = 0; s < N; s++) mst[s] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) cyc();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] em, nz;
            em = '0; nz = '0;
            for (int s = 0; s < N; s++) begin
                em[s] = (mst[s] == 0);
                nz[s] = (mst[s] != 0);
            end
            alloc_mask  = $urandom & $urandom & $urandom & em;
            alloc_rdy   = $urandom;
            wake_mask   = $urandom & $urandom;
            replay_mask = $urandom & $urandom & $urandom;
            done_mask   = $urandom & $urandom & $urandom & $urandom & nz;
            issue_ready = NA'($urandom);
            if ($urandom_range(0, 3) == 0) head = head + LN'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) begin
                kill_valid = 1'b1;
                kill_from  = LN'($urandom);
            end
            cyc();
        end

        repeat (3) @(negedge clk);
        #3;
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
